// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback definitions: default widths, zero-register index, FSM encoding, requester ids.
// Optional round-robin arbitration is selected elsewhere by WB_RR_ARB_EN.
package wb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZR_REG = 5'd31;

  // State names the requester whose write is on rf_* this cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ALU = 2'd1,
    WR_MEM = 2'd2
  } wb_state_e;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requesters, decode issue/hazard lookup and the register-file write port.
// master = pipeline side driving requests, slave = arbiter.
interface regfile_wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int unsigned AW = wb_pkg::ADDR_W,
  parameter int unsigned DW = wb_pkg::DATA_W
);
  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_reg;
  logic [DW-1:0]     alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [AW-1:0]     mem_reg;
  logic [DW-1:0]     mem_data;
  logic              issue_valid;
  logic [AW-1:0]     issue_reg;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic              hazard;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [2**AW-1:0]  pending;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output issue_valid, issue_reg, rs1, rs2,
    input  alu_ready, mem_ready, hazard,
    input  rf_we, rf_waddr, rf_wdata, pending
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  issue_valid, issue_reg, rs1, rs2,
    output alu_ready, mem_ready, hazard,
    output rf_we, rf_waddr, rf_wdata, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared when the write is accepted.
// A set and clear of the same register on one edge leaves the bit set; the zero register never pends.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned           ADDR_W = wb_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]     ZR_REG = wb_pkg::ZR_REG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en_i,
  input  logic [ADDR_W-1:0]    set_reg_i,
  input  logic                 clr_en_i,
  input  logic [ADDR_W-1:0]    clr_reg_i,
  input  logic [ADDR_W-1:0]    rs1_i,
  input  logic [ADDR_W-1:0]    rs2_i,
  output logic                 hazard_o,
  output logic [2**ADDR_W-1:0] pending_o
);

  logic [2**ADDR_W-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_reg_i] = 1'b0;
    // Applied after the clear so a newer producer stays outstanding
    if (set_en_i && (set_reg_i != ZR_REG)) pending_d[set_reg_i] = 1'b1;
    pending_d[ZR_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending_o = pending_q;
  assign hazard_o  = pending_q[rs1_i] | pending_q[rs2_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port; one write per cycle,
// registered one cycle after acceptance. Define WB_RR_ARB_EN for round-robin instead of mem>ALU priority.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned       DATA_W = wb_pkg::DATA_W,
  parameter int unsigned       ADDR_W = wb_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ZR_REG = wb_pkg::ZR_REG
) (
  input logic           clk,
  input logic           rst_n,
  regfile_wb_arbiter_if.slave bus
);

  wb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic               grant_alu, grant_mem;
  logic               clr_en;
  logic [ADDR_W-1:0]  clr_reg;

`ifdef WB_RR_ARB_EN
  logic last_grant_q, last_grant_d;

  // On contention, serve whoever was not granted last
  always_comb begin
    grant_mem = rst_n & bus.mem_valid & (~bus.alu_valid | (last_grant_q == REQ_ALU));
    grant_alu = rst_n & bus.alu_valid & ~grant_mem;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_mem)      last_grant_d = REQ_MEM;
    else if (grant_alu) last_grant_d = REQ_ALU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= REQ_ALU;
    else        last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant_mem = rst_n & bus.mem_valid;
    grant_alu = rst_n & bus.alu_valid & ~bus.mem_valid;
  end
`endif

  always_comb begin
    state_d    = IDLE;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    clr_en     = 1'b0;
    clr_reg    = bus.alu_reg;
    if (grant_mem) begin
      state_d    = WR_MEM;
      rf_waddr_d = bus.mem_reg;
      rf_wdata_d = bus.mem_data;
      clr_en     = 1'b1;
      clr_reg    = bus.mem_reg;
    end else if (grant_alu) begin
      state_d    = WR_ALU;
      rf_waddr_d = bus.alu_reg;
      rf_wdata_d = bus.alu_data;
      clr_en     = 1'b1;
      clr_reg    = bus.alu_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  // Zero-register writes still occupy a slot but never reach the register file
  assign bus.rf_we     = (state_q != IDLE) && (rf_waddr_q != ZR_REG);
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .ZR_REG (ZR_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (bus.issue_valid),
    .set_reg_i (bus.issue_reg),
    .clr_en_i  (clr_en),
    .clr_reg_i (clr_reg),
    .rs1_i     (bus.rs1),
    .rs2_i     (bus.rs2),
    .hazard_o  (bus.hazard),
    .pending_o (bus.pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single-requester vector table plus hand-written
// sequences for reset, collision, zero register, scoreboard and arbitration order.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        e_ardy;
    logic        e_mrdy;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_reg     = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_reg     = '0;
    bus.mem_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_reg   = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle_inputs();
    rst_n = 1'b0;

    //            av  ar     ad            mv  mr     md            ardy mrdy we  addr   data
    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 5'd9,  32'hCAFE_F00D};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd31, 32'h1111_2222, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 5'd31, 32'h1111_2222};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd30, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 5'd30, 32'h0000_0001};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_we",      {31'd0, bus.rf_we}, 32'd0);
    chk("rst_waddr",   {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_wdata",   bus.rf_wdata, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);

    // Reset asserted mid-cycle while a write is in flight and mem_valid is held
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd4;
    bus.mem_valid   = 1'b1;
    bus.mem_reg     = 5'd6;
    bus.mem_data    = 32'h55;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    chk("pre_rst_we",      {31'd0, bus.rf_we}, 32'd1);
    chk("pre_rst_pending", bus.pending, 32'h0000_0010);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we",      {31'd0, bus.rf_we}, 32'd0);
    chk("midrst_pending", bus.pending, 32'd0);
    chk("midrst_mrdy",    {31'd0, bus.mem_ready}, 32'd0);
    chk("midrst_ardy",    {31'd0, bus.alu_ready}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = vecs[i].av;
      bus.alu_reg   = vecs[i].ar;
      bus.alu_data  = vecs[i].ad;
      bus.mem_valid = vecs[i].mv;
      bus.mem_reg   = vecs[i].mr;
      bus.mem_data  = vecs[i].md;
      #1;
      chk($sformatf("v%0d_ardy", i), {31'd0, bus.alu_ready}, {31'd0, vecs[i].e_ardy});
      chk($sformatf("v%0d_mrdy", i), {31'd0, bus.mem_ready}, {31'd0, vecs[i].e_mrdy});
      @(negedge clk);
      idle_inputs();
      chk($sformatf("v%0d_we", i), {31'd0, bus.rf_we}, {31'd0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, bus.rf_waddr}, {27'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_wdata", i), bus.rf_wdata, vecs[i].e_data);
      end
    end
    @(negedge clk);
    chk("idle_we", {31'd0, bus.rf_we}, 32'd0);

    // Same destination from both requesters: load first, ALU value lands last
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd7;
    bus.alu_data  = 32'hBBBB;
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd7;
    bus.mem_data  = 32'hAAAA;
    #1;
    chk("col_ardy0", {31'd0, bus.alu_ready}, 32'd0);
    chk("col_mrdy0", {31'd0, bus.mem_ready}, 32'd1);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("col_we1",    {31'd0, bus.rf_we}, 32'd1);
    chk("col_waddr1", {27'd0, bus.rf_waddr}, 32'd7);
    chk("col_wdata1", bus.rf_wdata, 32'hAAAA);
    #1;
    chk("col_ardy1", {31'd0, bus.alu_ready}, 32'd1);
    @(negedge clk);
    bus.alu_valid = 1'b0;
    chk("col_we2",    {31'd0, bus.rf_we}, 32'd1);
    chk("col_wdata2", bus.rf_wdata, 32'hBBBB);
    @(negedge clk);
    chk("col_we3", {31'd0, bus.rf_we}, 32'd0);

    // Zero register: accepted, not written, never pending, never a hazard
    bus.mem_valid   = 1'b1;
    bus.mem_reg     = 5'd31;
    bus.mem_data    = 32'h1;
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd31;
    bus.rs1         = 5'd31;
    bus.rs2         = 5'd31;
    #1;
    chk("zr_mrdy", {31'd0, bus.mem_ready}, 32'd1);
    @(negedge clk);
    idle_inputs();
    chk("zr_we",      {31'd0, bus.rf_we}, 32'd0);
    chk("zr_pending", bus.pending, 32'd0);
    bus.rs1 = 5'd31;
    bus.rs2 = 5'd31;
    #1;
    chk("zr_hazard", {31'd0, bus.hazard}, 32'd0);

    // Scoreboard set, hazard lookup, clear on acceptance, set-wins on same edge
    @(negedge clk);
    idle_inputs();
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd3;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.rs1         = 5'd3;
    #1;
    chk("sb_pending_set", bus.pending, 32'h0000_0008);
    chk("sb_hazard_rs1",  {31'd0, bus.hazard}, 32'd1);
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd3;
    #1;
    chk("sb_hazard_rs2", {31'd0, bus.hazard}, 32'd1);
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd3;
    bus.alu_data  = 32'h33;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    chk("sb_clr_hazard",  {31'd0, bus.hazard}, 32'd0);
    chk("sb_clr_pending", bus.pending, 32'd0);
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd3;
    @(negedge clk);
    chk("sb_reset_hazard", {31'd0, bus.hazard}, 32'd1);
    bus.alu_valid   = 1'b1;
    bus.alu_reg     = 5'd3;
    bus.alu_data    = 32'h44;
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd3;
    @(negedge clk);
    idle_inputs();
    bus.rs1 = 5'd3;
    #1;
    chk("sb_setwins_pending", bus.pending, 32'h0000_0008);
    chk("sb_setwins_hazard",  {31'd0, bus.hazard}, 32'd1);
    chk("sb_setwins_we",      {31'd0, bus.rf_we}, 32'd1);
    chk("sb_setwins_waddr",   {27'd0, bus.rf_waddr}, 32'd3);

    // Both requesters held valid for four cycles
    @(negedge clk);
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd10;
    bus.alu_data  = 32'hA1;
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd11;
    bus.mem_data  = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      logic exp_mem;
`ifdef WB_RR_ARB_EN
      exp_mem = (i % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      #1;
      chk($sformatf("arb%0d_mrdy", i), {31'd0, bus.mem_ready}, {31'd0, exp_mem});
      chk($sformatf("arb%0d_ardy", i), {31'd0, bus.alu_ready}, {31'd0, ~exp_mem});
      @(negedge clk);
      chk($sformatf("arb%0d_waddr", i), {27'd0, bus.rf_waddr}, exp_mem ? 32'd11 : 32'd10);
    end
    idle_inputs();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
